// File: rtl/ternary_stream_tx.sv
// Streams packed ternary weights, then activation words, into the accelerator and
// tags each returned result with the accelerator row that produced it.
module ternary_stream_tx #(
    parameter int unsigned MAX_IN_LEN  = 16,
    parameter int unsigned MAX_OUT_LEN = 8,
    parameter int unsigned RES_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        vec_valid,
    input  logic [15:0] vec_data,
    input  logic        vec_last,
    output logic        vec_ready,
    output logic [15:0] tx_word,
    output logic        acc_rst_n,
    input  logic [7:0]  rx_data,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic [2:0]  res_row,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARST  = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_MULT  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    localparam int unsigned COL_W = (MAX_IN_LEN > 1) ? $clog2(MAX_IN_LEN) : 1;
    localparam int unsigned DR_W  = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAX_IN_LEN - 1);
    localparam logic [2:0]       LAST_ROW = 3'(MAX_OUT_LEN - 1);
    localparam logic [DR_W-1:0]  LAST_DR  = DR_W'(RES_LAT - 1);

    logic [2:0]       r_state, w_state;
    logic [COL_W-1:0] r_col, w_col;
    logic [2:0]       r_row, w_row;
    logic [DR_W-1:0]  r_drain, w_drain;
    logic [15:0]      r_tx, w_tx;
    logic             r_tx_vld, w_tx_vld;
    logic             r_vec_ready, w_vec_ready;
    logic             r_done, w_done;
    logic             r_acc_rst_n, r_busy;
    logic             r_res_valid;
    logic [7:0]       r_res_data;
    logic [2:0]       r_res_row;
    logic [15:0]      r_buf [MAX_IN_LEN];
    logic [RES_LAT-1:0]      r_pipe_vld;
    logic [RES_LAT-1:0][2:0] r_pipe_row;

    logic        w_accept;
    logic [15:0] w_mult_tx;
    logic        w_mult_rdy;

    // tx_word is registered, so vec_ready leads the MULT cycles by one: a word
    // accepted at the end of cycle N is on tx_word during cycle N+1.
    assign w_accept   = r_vec_ready & vec_valid;
    assign w_mult_tx  = w_accept ? vec_data : '0;
    assign w_mult_rdy = ~(w_accept & vec_last);

    always_comb begin
        w_state     = r_state;
        w_col       = r_col;
        w_row       = r_row;
        w_drain     = r_drain;
        w_tx        = '0;
        w_tx_vld    = 1'b0;
        w_vec_ready = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state = S_ARST;
                end
            end
            S_ARST: begin
                w_state = S_HDR;
                w_tx    = '1;
            end
            S_HDR: begin
                w_state     = S_LOAD;
                w_col       = '0;
                w_tx        = r_buf[0];
                w_vec_ready = (LAST_COL == '0);
            end
            S_LOAD: begin
                if (r_col == LAST_COL) begin
                    w_state     = S_MULT;
                    w_row       = '0;
                    w_tx        = w_mult_tx;
                    w_tx_vld    = w_accept;
                    w_vec_ready = w_mult_rdy;
                end else begin
                    w_col       = r_col + 1'b1;
                    w_tx        = r_buf[w_col];
                    w_vec_ready = (w_col == LAST_COL);
                end
            end
            S_MULT: begin
                if (!r_vec_ready) begin
                    w_state = S_DRAIN;
                    w_drain = '0;
                end else begin
                    w_row       = (r_row == LAST_ROW) ? 3'd0 : r_row + 3'd1;
                    w_tx        = w_mult_tx;
                    w_tx_vld    = w_accept;
                    w_vec_ready = w_mult_rdy;
                end
            end
            S_DRAIN: begin
                if (r_drain == LAST_DR) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                end else begin
                    w_drain = r_drain + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_drain     <= '0;
            r_tx        <= '0;
            r_tx_vld    <= 1'b0;
            r_vec_ready <= 1'b0;
            r_done      <= 1'b0;
            r_acc_rst_n <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_col       <= w_col;
            r_row       <= w_row;
            r_drain     <= w_drain;
            r_tx        <= w_tx;
            r_tx_vld    <= w_tx_vld;
            r_vec_ready <= w_vec_ready;
            r_done      <= w_done;
            r_acc_rst_n <= (w_state != S_ARST);
            r_busy      <= (w_state != S_IDLE);
        end
    end

    // Row tags follow each sent word through the accelerator latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe_vld  <= '0;
            r_pipe_row  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_row   <= '0;
        end else begin
            r_pipe_vld[0] <= r_tx_vld;
            r_pipe_row[0] <= r_row;
            for (int unsigned i = 1; i < RES_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_row[i] <= r_pipe_row[i-1];
            end
            r_res_valid <= r_pipe_vld[RES_LAT-1];
            if (r_pipe_vld[RES_LAT-1]) begin
                r_res_data <= rx_data;
                r_res_row  <= r_pipe_row[RES_LAT-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && wr_en && 32'(wr_addr) < MAX_IN_LEN) begin
            r_buf[wr_addr[COL_W-1:0]] <= wr_data;
        end
    end

    assign vec_ready = r_vec_ready;
    assign tx_word   = r_tx;
    assign acc_rst_n = r_acc_rst_n;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_row   = r_res_row;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ternary_stream_tx.sv
// Bench for ternary_stream_tx: session scenarios from a table plus random sessions,
// each compared cycle by cycle against an expected transmit/result trace.
module tb_ternary_stream_tx;

    localparam int unsigned TB_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        vec_valid;
    logic [15:0] vec_data;
    logic        vec_last;
    logic        vec_ready;
    logic [15:0] tx_word;
    logic        acc_rst_n;
    logic [7:0]  rx_data;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [2:0]  res_row;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [15:0] wmodel [16];
    logic [7:0]  rx_pipe [TB_LAT];

    typedef struct {
        int          len;
        logic [31:0] mask;
        bit          disturb;
        int          exp_nres;
        int          exp_last_row;
        int          exp_done;
    } vec_t;

    ternary_stream_tx #(
        .MAX_IN_LEN (16),
        .MAX_OUT_LEN(8),
        .RES_LAT    (TB_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .vec_valid(vec_valid),
        .vec_data (vec_data),
        .vec_last (vec_last),
        .vec_ready(vec_ready),
        .tx_word  (tx_word),
        .acc_rst_n(acc_rst_n),
        .rx_data  (rx_data),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_row  (res_row),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Stand-in accelerator: a fixed function of the word sent TB_LAT cycles earlier.
    function automatic logic [7:0] acc_fn(input logic [15:0] w);
        return w[15:8] ^ {w[6:0], w[7]} ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        rx_pipe[0] <= acc_fn(tx_word);
        for (int i = 1; i < TB_LAT; i++) rx_pipe[i] <= rx_pipe[i-1];
    end
    assign rx_data = rx_pipe[TB_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic write_buf(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wmodel[a] = d;
    endtask

    // One session from start to done. Expected trace: ARST 0, header FFFF, the 16
    // weights, one MULT cycle per schedule slot (word or bubble), then zeros.
    task automatic run_session(input int len, input logic [31:0] mask, input bit disturb,
                               output int n_res, output int last_row, output int done_idx);
        logic [15:0] words [$];
        logic [15:0] exp_tx [$];
        int          exp_cyc [$];
        logic [7:0]  exp_dat [$];
        int          exp_row [$];
        int          dn;
        int          total;
        int          rp;
        dn    = 18 + len + int'(TB_LAT);
        total = dn + 4;
        for (int k = 0; k < len; k++) words.push_back(16'($urandom));
        exp_tx.push_back(16'h0000);
        exp_tx.push_back(16'hFFFF);
        for (int c = 0; c < 16; c++) exp_tx.push_back(wmodel[c]);
        for (int k = 0; k < len; k++) begin
            exp_tx.push_back(mask[k] ? words[k] : 16'h0000);
            if (mask[k]) begin
                exp_cyc.push_back(18 + k + int'(TB_LAT) + 1);
                exp_dat.push_back(acc_fn(words[k]));
                exp_row.push_back(k % 8);
            end
        end
        while (exp_tx.size() < total) exp_tx.push_back(16'h0000);
        n_res = 0; last_row = -1; done_idx = -1; rp = 0;

        start = 1'b1;
        tick();
        start = 1'b0;
        fork
            begin
                for (int i = 0; i < total; i++) begin
                    logic expv;
                    chk($sformatf("tx_word[%0d]", i), 32'(tx_word), 32'(exp_tx[i]));
                    chk($sformatf("acc_rst_n[%0d]", i), 32'(acc_rst_n), 32'(i != 0));
                    chk($sformatf("busy[%0d]", i), 32'(busy), 32'(i < dn));
                    chk($sformatf("done[%0d]", i), 32'(done), 32'(i == dn));
                    expv = (rp < exp_cyc.size()) && (exp_cyc[rp] == i);
                    chk($sformatf("res_valid[%0d]", i), 32'(res_valid), 32'(expv));
                    if (expv && res_valid) begin
                        chk($sformatf("res_data[%0d]", i), 32'(res_data), 32'(exp_dat[rp]));
                        chk($sformatf("res_row[%0d]", i), 32'(res_row), 32'(exp_row[rp]));
                    end
                    if (expv) rp++;
                    if (res_valid) begin
                        n_res++;
                        last_row = int'(res_row);
                    end
                    if (done && done_idx < 0) done_idx = i;
                    tick();
                end
            end
            begin
                int w;
                if (disturb) begin
                    repeat (4) tick();
                    wr_en   = 1'b1;
                    wr_addr = 4'd3;
                    wr_data = ~wmodel[3];
                    start   = 1'b1;
                    tick();
                    wr_en   = 1'b0;
                    start   = 1'b0;
                end
                w = 0;
                while (!vec_ready && w < 40) begin
                    tick();
                    w++;
                end
                if (!vec_ready) chk("vec_ready_wait", 32'(vec_ready), 32'd1);
                for (int k = 0; k < len; k++) begin
                    vec_valid = mask[k];
                    vec_data  = words[k];
                    vec_last  = (k == len - 1);
                    tick();
                end
                vec_valid = 1'b0;
                vec_last  = 1'b0;
                vec_data  = '0;
            end
        join
    endtask

    initial begin
        vec_t tbl [6];
        int   nres, lrow, didx;

        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        vec_valid = 1'b0; vec_data = '0; vec_last = 1'b0;
        #1;
        chk("rst_tx_word", 32'(tx_word), 32'd0);
        chk("rst_acc_rst_n", 32'(acc_rst_n), 32'd0);
        chk("rst_vec_ready", 32'(vec_ready), 32'd0);
        chk("rst_res", {res_valid, res_data, res_row}, 32'd0);
        chk("rst_busy_done", {busy, done}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("acc_rst_n_after_rst", 32'(acc_rst_n), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++) write_buf(i, 16'(16'h0101 * i));

        tbl[0] = '{4,  32'h0000_000F, 1'b0, 4,  3, 22 + int'(TB_LAT)};
        tbl[1] = '{9,  32'h0000_0155, 1'b0, 5,  0, 27 + int'(TB_LAT)};
        tbl[2] = '{10, 32'h0000_03FF, 1'b0, 10, 1, 28 + int'(TB_LAT)};
        tbl[3] = '{1,  32'h0000_0001, 1'b0, 1,  0, 19 + int'(TB_LAT)};
        tbl[4] = '{5,  32'h0000_001F, 1'b1, 5,  4, 23 + int'(TB_LAT)};
        tbl[5] = '{5,  32'h0000_001F, 1'b0, 5,  4, 23 + int'(TB_LAT)};
        for (int t = 0; t < 6; t++) begin
            run_session(tbl[t].len, tbl[t].mask, tbl[t].disturb, nres, lrow, didx);
            chk($sformatf("tbl%0d_nres", t), 32'(nres), 32'(tbl[t].exp_nres));
            chk($sformatf("tbl%0d_last_row", t), 32'(lrow), 32'(tbl[t].exp_last_row));
            chk($sformatf("tbl%0d_done_idx", t), 32'(didx), 32'(tbl[t].exp_done));
            tick();
        end

        // Reset while LOAD is presenting column 7.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("load_col7", 32'(tx_word), 32'(wmodel[7]));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tx_word", 32'(tx_word), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_acc_rst_n", 32'(acc_rst_n), 32'd0);
        chk("midrst_vec_ready", 32'(vec_ready), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("post_rst_quiet[%0d]", i), {tx_word, busy, done, res_valid}, 32'd0);
            tick();
        end
        for (int i = 0; i < 16; i++) write_buf(i, 16'($urandom));
        run_session(3, 32'h7, 1'b0, nres, lrow, didx);
        chk("after_rst_nres", 32'(nres), 32'd3);

        for (int s = 0; s < 12; s++) begin
            int          len;
            logic [31:0] mask;
            if (s % 3 == 0) begin
                for (int i = 0; i < 16; i++) if ($urandom_range(0, 1) == 1) write_buf(i, 16'($urandom));
            end
            len  = $urandom_range(1, 24);
            mask = $urandom;
            mask[len-1] = 1'b1;
            run_session(len, mask, 1'b0, nres, lrow, didx);
            chk($sformatf("rand%0d_done_idx", s), 32'(didx), 32'(18 + len + int'(TB_LAT)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
